// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and types for banked_mem_responder.
//   NUM_BANKS                  number of interleaved banks
//   BANK_SEL_LO / BANK_SEL_HI  address bits that select the bank
//   DEF_BANK_BUSY              default bank occupancy in cycles (minimum 3)
//   DEF_READ_LAT               default read latency in cycles (fixed at 2)
//   bank_idx_t                 bank index type
package mem_pkg;
    localparam int NUM_BANKS     = 4;
    localparam int BANK_SEL_LO   = 1;
    localparam int BANK_SEL_HI   = 2;
    localparam int DEF_BANK_BUSY = 4;
    localparam int DEF_READ_LAT  = 2;

    typedef logic [1:0] bank_idx_t;
endpackage

// File: rtl/mem_bank.sv
// mem_bank: one bank of the interleaved memory. It holds the storage array,
// the occupancy down-counter and the read pipe.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   accept      the top level accepted a request for this bank this cycle
//   we          the accepted request is a write (otherwise it is a read)
//   row         row index inside the bank
//   wdata       write data
//   busy        the bank cannot accept this cycle (registered counter != 0)
//   rvalid      read data completes this cycle
//   rdata       read data, zero when rvalid is low
module mem_bank
    import mem_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ROW_W     = 13,
    parameter int BANK_BUSY = DEF_BANK_BUSY,
    parameter int READ_LAT  = DEF_READ_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              accept,
    input  logic              we,
    input  logic [ROW_W-1:0]  row,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);
    localparam int CNT_W = $clog2(BANK_BUSY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BANK_BUSY - 1);

    logic [DATA_W-1:0] mem [2**ROW_W];
    logic [CNT_W-1:0]  cnt;
    logic [READ_LAT-1:0]             pipe_v;
    logic [READ_LAT-1:0][DATA_W-1:0] pipe_d;
    logic rd_acc;

    assign rd_acc = accept & ~we;

    // Storage has no reset so that committed writes survive a reset pulse.
    always_ff @(posedge clk) begin
        if (accept && we) begin
            mem[row] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Stage 0 captures the array at the accepting edge; the last stage is the
    // completion cycle. Data is zeroed when no read enters so the top can OR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v <= '0;
            pipe_d <= '0;
        end else begin
            pipe_v <= {pipe_v[READ_LAT-2:0], rd_acc};
            pipe_d <= {pipe_d[READ_LAT-2:0], (rd_acc ? mem[row] : {DATA_W{1'b0}})};
        end
    end

    assign busy   = (cnt != '0);
    assign rvalid = pipe_v[READ_LAT-1];
    assign rdata  = pipe_d[READ_LAT-1];
endmodule

// File: rtl/banked_mem_responder.sv
// banked_mem_responder: four-bank word-interleaved memory serving cache
// line-fill and eviction traffic. Bank = addr[2:1], row = addr[ADDR_W-1:3].
// Optional feature macro: MEM_ALIGN_CHECK_EN (odd byte address raises err).
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   addr        byte address
//   data_in     write data
//   wr, rd      write / read request
//   data_out    read data in the completion cycle, otherwise 0
//   stall       request not accepted because the target bank is busy
//   busy        per-bank busy vector
//   err         protocol error this cycle; request dropped
module banked_mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int BANK_BUSY = DEF_BANK_BUSY,
    parameter int READ_LAT  = DEF_READ_LAT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    data_in,
    input  logic                 wr,
    input  logic                 rd,
    output logic [DATA_W-1:0]    data_out,
    output logic                 stall,
    output logic [NUM_BANKS-1:0] busy,
    output logic                 err
);
    localparam int ROW_W = ADDR_W - 3;

    bank_idx_t            bank;
    logic [ROW_W-1:0]     row;
    logic                 req;
    logic                 accept;
    logic [NUM_BANKS-1:0] bank_accept;
    logic [NUM_BANKS-1:0] bank_rvalid;
    logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];

    assign bank = addr[BANK_SEL_HI:BANK_SEL_LO];
    assign row  = addr[ADDR_W-1:3];
    assign req  = rd | wr;

`ifdef MEM_ALIGN_CHECK_EN
    assign err = (rd & wr) | (req & addr[0]);
`else
    // Byte offset is meaningless for word accesses when alignment is not checked.
    logic unused_addr_lsb;
    assign unused_addr_lsb = addr[0];
    assign err = rd & wr;
`endif

    assign stall  = req & ~err & busy[bank];
    assign accept = req & ~err & ~busy[bank];

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        assign bank_accept[g] = accept & (bank == bank_idx_t'(g));

        mem_bank #(
            .DATA_W    (DATA_W),
            .ROW_W     (ROW_W),
            .BANK_BUSY (BANK_BUSY),
            .READ_LAT  (READ_LAT)
        ) u_bank (
            .clk    (clk),
            .rst_n  (rst_n),
            .accept (bank_accept[g]),
            .we     (wr),
            .row    (row),
            .wdata  (data_in),
            .busy   (busy[g]),
            .rvalid (bank_rvalid[g]),
            .rdata  (bank_rdata[g])
        );
    end

    // At most one acceptance per cycle, so at most one bank completes per cycle.
    always_comb begin
        data_out = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_rvalid[b]) begin
                data_out = data_out | bank_rdata[b];
            end
        end
    end
endmodule

// File: doc/banked_mem_responder.md
# banked_mem_responder

Four-bank interleaved data memory that answers the cache controller's line-fill and eviction traffic. Words are interleaved across banks by address bits [2:1]; each bank is occupied for a fixed number of cycles after accepting a request and reports this on a per-bank busy vector. Reads return data a fixed two cycles after acceptance. Sits between the cache FSM (initiator) and the backing storage. Both instruction and data caches instantiate it.

## Interface
Parameters:
- DATA_W, 16, word width
- ADDR_W, 16, byte address width; word index is addr[ADDR_W-1:1]
- BANK_BUSY, 4, cycles per bank access; minimum 3
- READ_LAT, 2, cycles from read acceptance to data_out valid; fixed, not tunable below 2

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- addr  in  ADDR_W  byte address; bank = addr[2:1], row = addr[ADDR_W-1:3]
- data_in  in  DATA_W  write data
- wr  in  1  write request
- rd  in  1  read request
- data_out  out  DATA_W  read data, valid only in completion cycle, else 0
- stall  out  1  request this cycle not accepted (target bank busy)
- busy  out  4  busy[b]=1: bank b cannot accept this cycle
- err  out  1  protocol error this cycle; request dropped

## Operation
- Request = rd|wr. Accepted iff request, not error, busy[bank]==0.
- Error conditions: rd&wr both high; with MEM_ALIGN_CHECK_EN, addr[0]==1. err=1 that cycle (combinational). No access, no busy change, stall=0.
- stall = request & ~err & busy[bank], combinational. Stalled requests are not queued; the initiator holds addr/rd/wr until accepted.
- Accepted write: storage[bank][row] <= data_in at the accepting edge.
- Accepted read: storage sampled at the accepting edge into a per-bank read pipe. data_out carries it READ_LAT cycles after acceptance.
- Per bank: down-counter loaded with BANK_BUSY-1 on acceptance. busy[b] = (count != 0). Registered; no combinational path from rd/wr to busy.
- Reads in different banks overlap freely. Completions are always on distinct cycles because acceptance is at most one per cycle. data_out is the OR of the completing bank's pipe output, or 0.
- Storage contents are not reset. Power-up contents are undefined; benches write before reading.

## Timing
- Reset (async assert, sync-free deassert): data_out=0, stall=0, err=0, busy=4'b0000, all busy counters 0, read pipes cleared.
- Reset mid-operation: in-flight reads are discarded; no data_out is produced after reset release. Writes already committed are retained.
- Read accepted at edge t: busy[b] is high for cycles t+1..t+BANK_BUSY-1, and data_out is valid in cycle t+READ_LAT. The bank next accepts in cycle t+BANK_BUSY.
- Back-to-back line fill (banks 0,1,2,3 in cycles t..t+3): data is returned in cycles t+2..t+5, one word per cycle, in issue order.
- Write then read of the same word: the read must wait for the bank (stall), then returns the new data.
- Write to bank b and read of another bank in the next cycle: independent.

## Configuration
- MEM_ALIGN_CHECK_EN defined: an odd address raises err and drops the request.
- MEM_ALIGN_CHECK_EN undefined: addr[0] is ignored, and err comes only from rd&wr.

## Structure
- Package mem_pkg holds:
  - NUM_BANKS=4
  - BANK_SEL_LO=1, BANK_SEL_HI=2
  - the default BANK_BUSY and READ_LAT
  - a typedef for the bank index (2 bits)
- Sub-module mem_bank, instantiated 4×. Each instance contains:
  - storage array of 2^(ADDR_W-3) words
  - busy counter
  - READ_LAT-deep read pipe with valid bit
  - inputs: accept, we, row, wdata
  - outputs: busy, rvalid, rdata
- The top level holds:
  - bank decode
  - err/stall logic
  - data_out OR-reduction

## Test plan
- Reset: assert rst_n=0 mid-read → data_out=0, busy=0000 immediately. No data_out after release.
- Line fill:
  - Write 0x1111/0x2222/0x3333/0x4444 to 0x0800/0x0802/0x0804/0x0806 in consecutive cycles.
  - Wait for busy=0000, then read all four in consecutive cycles.
  - Expect data_out 0x1111..0x4444 in cycles t+2..t+5, stall never high.
- Bank conflict:
  - Read 0x0010, then read 0x0018 (same bank 0) in the next cycle.
  - Expect stall=1 for cycles t+1..t+3, acceptance at t+4, data 2 cycles later.
- rd=wr=1 at 0x0004 → err=1, stall=0, busy unchanged, storage at 0x0004 unchanged.
- Odd address 0x0003 read:
  - With MEM_ALIGN_CHECK_EN: err=1, no data_out.
  - Without: returns the word at 0x0002.
- Write 0xBEEF to 0x1234, then read 0x1234 immediately → stalled until busy clears, then data_out=0xBEEF.
